// File: rtl/eth_pkg.sv
// Shared Ethernet framing definitions for the transmit framer and the
// receive-side FCS checker.
//   - Preamble / SFD byte values and preamble length
//   - Reflected CRC-32 polynomial, initial value and good-frame residue
//   - Transmit framer state encoding
package eth_pkg;

    localparam logic [7:0]  PREAMBLE_BYTE = 8'h55;
    localparam logic [7:0]  SFD_BYTE      = 8'hD5;
    localparam int          PREAMBLE_LEN  = 7;

    localparam logic [31:0] CRC32_POLY    = 32'hEDB88320;
    localparam logic [31:0] CRC32_INIT    = 32'hFFFFFFFF;
    // Register value left after running the CRC over data followed by its FCS.
    localparam logic [31:0] CRC32_RESIDUE = 32'hDEBB20E3;

    typedef enum logic [3:0] {
        IDLE,
        PREAMBLE,
        SFD,
        PAYLOAD,
        PAD,
        FCS,
        ABORT,
        DRAIN,
        IFG
    } tx_state_t;

endpackage

// File: rtl/crc32_d8.sv
// Combinational reflected CRC-32 update, one byte per call.
// Ports:
//   i_crc  [31:0]  current CRC register
//   i_data [7:0]   byte to fold in, LSB first
//   o_crc  [31:0]  CRC register after the byte
module crc32_d8
    import eth_pkg::*;
(
    input  logic [31:0] i_crc,
    input  logic [7:0]  i_data,
    output logic [31:0] o_crc
);

    logic [31:0] w_crc;

    // Bit-serial shift register unrolled over the eight data bits.
    always_comb begin
        w_crc = i_crc;
        for (int i = 0; i < 8; i++) begin
            if (w_crc[0] ^ i_data[i]) begin
                w_crc = (w_crc >> 1) ^ CRC32_POLY;
            end else begin
                w_crc = w_crc >> 1;
            end
        end
    end

    assign o_crc = w_crc;

endmodule

// File: rtl/eth_tx_framer.sv
// Ethernet transmit framer: turns a valid/ready/last byte stream into a GMII
// frame (preamble, SFD, payload, zero pad, FCS) followed by an inter-frame gap.
// Underrun or oversize frames are terminated with a TX_ER cycle and the rest of
// the source frame is drained.
// Ports:
//   clkIn        125 MHz transmit clock
//   rstNIn       asynchronous active-low reset
//   txDataIn     payload byte from source
//   txValidIn    txDataIn valid
//   txLastIn     final payload byte of frame
//   txReadyOut   byte accepted when txValidIn && txReadyOut
//   txdOut       GMII TXD
//   txEnOut      GMII TX_EN
//   txErOut      GMII TX_ER
//   frameCntOut  completed frames, wraps
//   abortCntOut  aborted frames, wraps
module eth_tx_framer
    import eth_pkg::*;
#(
    parameter int MIN_PAYLOAD = 60,
    parameter int MAX_PAYLOAD = 1514,
    parameter int IFG_BYTES   = 12     // 1..255
) (
    input  logic        clkIn,
    input  logic        rstNIn,
    input  logic [7:0]  txDataIn,
    input  logic        txValidIn,
    input  logic        txLastIn,
    output logic        txReadyOut,
    output logic [7:0]  txdOut,
    output logic        txEnOut,
    output logic        txErOut,
    output logic [15:0] frameCntOut,
    output logic [15:0] abortCntOut
);

    localparam logic [10:0] MIN_CNT  = 11'(MIN_PAYLOAD);
    localparam logic [10:0] MAX_CNT  = 11'(MAX_PAYLOAD);
    localparam logic [7:0]  PRE_LAST = 8'(PREAMBLE_LEN);
    localparam logic [7:0]  IFG_LAST = 8'(IFG_BYTES);

    tx_state_t   r_state, w_stateNext;
    logic [7:0]  r_txd, w_txdNext;
    logic        r_txEn, w_txEnNext;
    logic        r_txEr, w_txErNext;
    logic        r_ready, w_readyNext;
    logic [10:0] r_byteCnt, w_byteCntNext, w_byteCntInc;
    logic [31:0] r_crc, w_crcNext, w_crcUpd, w_fcsWord;
    logic [7:0]  r_phase, w_phaseNext;
    logic [15:0] r_frameCnt, r_abortCnt;
    logic [11:0] w_padLeft;
    logic [7:0]  w_crcByte;
    logic [1:0]  w_fcsNextIdx;
    logic        w_trailer, w_needPad, w_start, w_frameDone, w_abortDone;

    // The cycle showing the last payload byte (PAYLOAD with ready low) and every
    // PAD cycle share one decision: another pad byte or the first FCS byte.
    assign w_trailer    = (r_state == PAD) || ((r_state == PAYLOAD) && !r_ready);
    assign w_padLeft    = {1'b0, MIN_CNT} - {1'b0, r_byteCnt};
    assign w_needPad    = !w_padLeft[11] && (w_padLeft != 12'd0);
    assign w_byteCntInc = (r_byteCnt == MAX_CNT) ? r_byteCnt : r_byteCnt + 11'd1;
    assign w_crcByte    = w_trailer ? 8'h00 : txDataIn;
    assign w_fcsWord    = ~r_crc;
    assign w_fcsNextIdx = r_phase[1:0] + 2'd1;

    crc32_d8 u_crc (
        .i_crc  (r_crc),
        .i_data (w_crcByte),
        .o_crc  (w_crcUpd)
    );

    // Next-state and next-output logic. Outputs are computed for the state being
    // entered so that every pin comes straight from a flop. CRC and byte count
    // advance on the edge that loads a payload or pad byte into txdOut.
    always_comb begin
        w_stateNext   = r_state;
        w_txdNext     = 8'h00;
        w_txEnNext    = 1'b0;
        w_txErNext    = 1'b0;
        w_readyNext   = 1'b0;
        w_byteCntNext = r_byteCnt;
        w_crcNext     = r_crc;
        w_phaseNext   = r_phase;
        w_start       = 1'b0;
        w_frameDone   = 1'b0;
        w_abortDone   = 1'b0;

        if (w_trailer) begin
            w_txEnNext = 1'b1;
            if (w_needPad) begin
                w_stateNext   = PAD;
                w_byteCntNext = w_byteCntInc;
                w_crcNext     = w_crcUpd;
            end else begin
                w_stateNext = FCS;
                w_phaseNext = 8'd0;
                w_txdNext   = w_fcsWord[7:0];
            end
        end else begin
            case (r_state)
                IDLE: begin
                    w_start = txValidIn;
                end
                PREAMBLE: begin
                    w_txEnNext = 1'b1;
                    if (r_phase == PRE_LAST) begin
                        w_stateNext = SFD;
                        w_txdNext   = SFD_BYTE;
                        w_readyNext = 1'b1;
                    end else begin
                        w_phaseNext = r_phase + 8'd1;
                        w_txdNext   = PREAMBLE_BYTE;
                    end
                end
                // Ready is high here; a missing byte is an underrun.
                SFD, PAYLOAD: begin
                    w_txEnNext = 1'b1;
                    if (txValidIn) begin
                        w_byteCntNext = w_byteCntInc;
                        w_crcNext     = w_crcUpd;
                        if ((w_byteCntInc == MAX_CNT) && !txLastIn) begin
                            w_stateNext = ABORT;
                            w_txErNext  = 1'b1;
                        end else begin
                            w_stateNext = PAYLOAD;
                            w_txdNext   = txDataIn;
                            w_readyNext = !txLastIn;
                        end
                    end else begin
                        w_stateNext = ABORT;
                        w_txErNext  = 1'b1;
                    end
                end
                FCS: begin
                    if (r_phase == 8'd3) begin
                        w_stateNext = IFG;
                        w_phaseNext = 8'd1;
                        w_frameDone = 1'b1;
                    end else begin
                        w_txEnNext  = 1'b1;
                        w_phaseNext = r_phase + 8'd1;
                        w_txdNext   = w_fcsWord[{w_fcsNextIdx, 3'b000} +: 8];
                    end
                end
                ABORT: begin
                    w_stateNext = DRAIN;
                    w_readyNext = 1'b1;
                    w_abortDone = 1'b1;
                end
                DRAIN: begin
                    if (txValidIn && txLastIn) begin
                        w_stateNext = IFG;
                        w_phaseNext = 8'd1;
                    end else begin
                        w_readyNext = 1'b1;
                    end
                end
                // The last gap cycle may launch the next frame directly so that
                // back-to-back frames see exactly IFG_BYTES idle cycles.
                IFG: begin
                    if (r_phase == IFG_LAST) begin
                        if (txValidIn) begin
                            w_start = 1'b1;
                        end else begin
                            w_stateNext = IDLE;
                        end
                    end else begin
                        w_phaseNext = r_phase + 8'd1;
                    end
                end
                default: begin
                    w_stateNext = IDLE;
                end
            endcase
        end

        if (w_start) begin
            w_stateNext   = PREAMBLE;
            w_txdNext     = PREAMBLE_BYTE;
            w_txEnNext    = 1'b1;
            w_phaseNext   = 8'd1;
            w_crcNext     = CRC32_INIT;
            w_byteCntNext = 11'd0;
        end
    end

    // State, datapath and output registers; reset abandons any frame in flight.
    always_ff @(posedge clkIn or negedge rstNIn) begin
        if (!rstNIn) begin
            r_state    <= IDLE;
            r_txd      <= 8'h00;
            r_txEn     <= 1'b0;
            r_txEr     <= 1'b0;
            r_ready    <= 1'b0;
            r_byteCnt  <= 11'd0;
            r_crc      <= CRC32_INIT;
            r_phase    <= 8'd0;
            r_frameCnt <= 16'd0;
            r_abortCnt <= 16'd0;
        end else begin
            r_state   <= w_stateNext;
            r_txd     <= w_txdNext;
            r_txEn    <= w_txEnNext;
            r_txEr    <= w_txErNext;
            r_ready   <= w_readyNext;
            r_byteCnt <= w_byteCntNext;
            r_crc     <= w_crcNext;
            r_phase   <= w_phaseNext;
            if (w_frameDone) begin
                r_frameCnt <= r_frameCnt + 16'd1;
            end
            if (w_abortDone) begin
                r_abortCnt <= r_abortCnt + 16'd1;
            end
        end
    end

    assign txdOut      = r_txd;
    assign txEnOut     = r_txEn;
    assign txErOut     = r_txEr;
    assign txReadyOut  = r_ready;
    assign frameCntOut = r_frameCnt;
    assign abortCntOut = r_abortCnt;

endmodule
